// File: rtl/s2p_deser.sv
`default_nettype none
// ============================================================================
// Module   : s2p_deser
// Brief    : Serial-to-parallel deserializer with a one-word output register
//            and a valid/ready handshake. Partial words are flushed when the
//            upstream serializer reports empty.
//            Optional macro S2P_DESER_OVERRUN_FLAG_EN adds a sticky overrun_o.
// Revision : 1.0 - initial release
// ============================================================================
module s2p_deser #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     serial_i,
    input  logic                     valid_i,
    input  logic                     empty_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(WIDTH)-1:0] bit_cnt_o
`ifdef S2P_DESER_OVERRUN_FLAG_EN
    ,
    output logic                     overrun_o
`endif
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_bit_cnt;
    logic [CW-1:0]    w_bit_cnt_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_data;
    logic             r_out_valid;
    logic [CW-1:0]    w_idx;
    logic             w_last;
    logic             w_flush;
    logic             w_accept;
    logic             w_load;

    // Bits are written in place by index rather than shifted, so every
    // register bit is live and bit order is a pure index mapping.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_idx = C_LAST - r_bit_cnt;
        end else begin : g_lsb_first
            assign w_idx = r_bit_cnt;
        end
    endgenerate

    // Word as it would look with the current serial bit merged in.
    always_comb begin
        w_word        = r_shreg;
        w_word[w_idx] = serial_i;
    end

    assign w_last   = valid_i && (r_bit_cnt == C_LAST);
    assign w_flush  = !valid_i && empty_i && (r_bit_cnt != '0);
    assign w_accept = r_out_valid && out_ready_i;
    assign w_load   = w_last && (!r_out_valid || out_ready_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shreg   <= w_shreg_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shreg_next   = r_shreg;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    w_state_next   = ST_SHIFT;
                    w_bit_cnt_next = CW'(1);
                    w_shreg_next   = w_word;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_next   = ST_IDLE;
                    w_bit_cnt_next = '0;
                    w_shreg_next   = '0;
                end else if (valid_i) begin
                    w_bit_cnt_next = r_bit_cnt + CW'(1);
                    w_shreg_next   = w_word;
                end else if (w_flush) begin
                    w_state_next   = ST_IDLE;
                    w_bit_cnt_next = '0;
                    w_shreg_next   = '0;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_bit_cnt_next = '0;
                w_shreg_next   = '0;
            end
        endcase
    end

    // Output register: a completing word loads if the slot is free or is
    // being consumed on this same edge; otherwise it is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_data      <= w_word;
            r_out_valid <= 1'b1;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef S2P_DESER_OVERRUN_FLAG_EN
    logic w_drop;
    logic r_overrun;

    assign w_drop = w_last && r_out_valid && !out_ready_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun_o = r_overrun;
`endif

    assign data_o      = r_data;
    assign out_valid_o = r_out_valid;
    assign bit_cnt_o   = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_s2p_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2p_deser
// Brief    : Scoreboard bench for s2p_deser (WIDTH=4, LSB first).
// Revision : 1.0 - initial release
// ============================================================================
module tb_s2p_deser;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             serial_i;
    logic             valid_i;
    logic             empty_i;
    logic [WIDTH-1:0] data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [1:0]       bit_cnt_o;
`ifdef S2P_DESER_OVERRUN_FLAG_EN
    logic             overrun_o;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q[$];

    s2p_deser #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_i    (serial_i),
        .valid_i     (valid_i),
        .empty_i     (empty_i),
        .data_o      (data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .bit_cnt_o   (bit_cnt_o)
`ifdef S2P_DESER_OVERRUN_FLAG_EN
        ,
        .overrun_o   (overrun_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a word is consumed on the next edge wherever valid and ready
    // are both high, so it is compared against the scoreboard at the negedge.
    always @(negedge clk) begin
        if (reset && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard: unexpected word %0h", data_o);
            end else begin
                check("scoreboard", 32'(data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        valid_i  = 1'b1;
        serial_i = b;
        tick();
        valid_i  = 1'b0;
        serial_i = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    initial begin
        #100000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $finish;
    end

    initial begin
        reset       = 1'b0;
        serial_i    = 1'b0;
        valid_i     = 1'b0;
        empty_i     = 1'b0;
        out_ready_i = 1'b0;
        #1;
        check("reset data", 32'(data_o), 32'h0);
        check("reset valid", 32'(out_valid_o), 32'h0);
        check("reset cnt", 32'(bit_cnt_o), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Basic word, ready high: 1,0,1,1 -> 4'b1101, valid for one cycle
        out_ready_i = 1'b1;
        exp_q.push_back(4'b1101);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("basic valid before last", 32'(out_valid_o), 32'h0);
        send_bit(1'b1);
        check("basic valid", 32'(out_valid_o), 32'h1);
        check("basic data", 32'(data_o), 32'hD);
        tick();
        check("basic valid one cycle", 32'(out_valid_o), 32'h0);

        // Gaps between bits: 1,1,0,0 -> 4'b0011, count 1,2,3,0
        exp_q.push_back(4'b0011);
        send_bit(1'b1);
        check("gap cnt 1", 32'(bit_cnt_o), 32'h1);
        tick();
        tick();
        check("gap cnt hold", 32'(bit_cnt_o), 32'h1);
        send_bit(1'b1);
        check("gap cnt 2", 32'(bit_cnt_o), 32'h2);
        tick();
        tick();
        send_bit(1'b0);
        check("gap cnt 3", 32'(bit_cnt_o), 32'h3);
        tick();
        tick();
        send_bit(1'b0);
        check("gap cnt 0", 32'(bit_cnt_o), 32'h0);
        check("gap data", 32'(data_o), 32'h3);
        tick();

        // Backpressure and overrun: 1101 held, 0110 dropped
        out_ready_i = 1'b0;
        exp_q.push_back(4'b1101);
        send_word(4'b1101);
        check("bp valid", 32'(out_valid_o), 32'h1);
        tick();
        check("bp data stable", 32'(data_o), 32'hD);
        send_word(4'b0110);
        check("overrun data kept", 32'(data_o), 32'hD);
        check("overrun valid", 32'(out_valid_o), 32'h1);
        check("overrun cnt", 32'(bit_cnt_o), 32'h0);
`ifdef S2P_DESER_OVERRUN_FLAG_EN
        check("overrun flag", 32'(overrun_o), 32'h1);
`endif
        out_ready_i = 1'b1;
        tick();
        check("bp valid falls", 32'(out_valid_o), 32'h0);

        // Same-edge handoff: hold 1101, consume it as 0101 completes
        out_ready_i = 1'b0;
        exp_q.push_back(4'b1101);
        exp_q.push_back(4'b0101);
        send_word(4'b1101);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        out_ready_i = 1'b1;
        send_bit(1'b0);
        check("handoff data", 32'(data_o), 32'h5);
        check("handoff valid", 32'(out_valid_o), 32'h1);
        tick();
        check("handoff drained", 32'(out_valid_o), 32'h0);
`ifdef S2P_DESER_OVERRUN_FLAG_EN
        check("overrun sticky", 32'(overrun_o), 32'h1);
`endif

        // Flush a partial word; valid_i outranks empty_i afterwards
        send_bit(1'b1);
        send_bit(1'b1);
        check("flush pre cnt", 32'(bit_cnt_o), 32'h2);
        empty_i = 1'b1;
        tick();
        check("flush cnt", 32'(bit_cnt_o), 32'h0);
        exp_q.push_back(4'b1110);
        send_bit(1'b0);
        check("valid over empty", 32'(bit_cnt_o), 32'h1);
        empty_i = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("flush data", 32'(data_o), 32'hE);
        tick();

        // Async reset with a held word and a partial word
        out_ready_i = 1'b0;
        send_word(4'b1001);
        send_bit(1'b1);
        send_bit(1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("async data", 32'(data_o), 32'h0);
        check("async valid", 32'(out_valid_o), 32'h0);
        check("async cnt", 32'(bit_cnt_o), 32'h0);
`ifdef S2P_DESER_OVERRUN_FLAG_EN
        check("async overrun", 32'(overrun_o), 32'h0);
`endif
        tick();
        tick();
        reset = 1'b1;
        out_ready_i = 1'b1;
        exp_q.push_back(4'b1101);
        send_word(4'b1101);
        check("post reset data", 32'(data_o), 32'hD);
        check("post reset valid", 32'(out_valid_o), 32'h1);
        tick();
        tick();

        check("queue drained", 32'(exp_q.size()), 32'h0);
        summary();
        $finish;
    end

endmodule
`default_nettype wire
